// File: rtl/rank_order_sorter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rank_order_sorter_if : image load, sort control and AER event bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface rank_order_sorter_if #(
  parameter int IMAGE_SIZE      = 256,
  parameter int PIXEL_MAX_VALUE = 255
);
  localparam int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE);
  localparam int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE);

  logic                       img_wr_en;
  logic [IMAGE_SIZE_BITS-1:0] img_wr_addr;
  logic [PIXEL_BITS-1:0]      img_wr_data;
  logic                       start;
  logic                       aerin_ctrl_busy;
  logic [IMAGE_SIZE_BITS+1:0] next_index;
  logic                       found_next_index;
  logic                       sort_busy;
  logic                       sort_done;

  modport master (
    output img_wr_en, img_wr_addr, img_wr_data, start, aerin_ctrl_busy,
    input  next_index, found_next_index, sort_busy, sort_done
  );

  modport slave (
    input  img_wr_en, img_wr_addr, img_wr_data, start, aerin_ctrl_busy,
    output next_index, found_next_index, sort_busy, sort_done
  );
endinterface
`default_nettype wire

// File: rtl/rank_order_sorter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rank_order_sorter : emits pixel indices in descending grey level order
// Rev 1.0
// ---------------------------------------------------------------------------
module rank_order_sorter #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 255,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
  parameter int MIN_LEVEL       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rank_order_sorter_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SCAN    = 3'd1,
    S_EMIT    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [IMAGE_SIZE_BITS-1:0] ADDR_LAST = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [IMAGE_SIZE_BITS:0]   SIZE_EXT  = (IMAGE_SIZE_BITS + 1)'(IMAGE_SIZE);
  localparam logic [PIXEL_BITS-1:0]      LEVEL_MAX = PIXEL_BITS'(PIXEL_MAX_VALUE);
  localparam logic [PIXEL_BITS-1:0]      LEVEL_MIN = PIXEL_BITS'(MIN_LEVEL);

  state_t                     state_q, state_d;
  logic [PIXEL_BITS-1:0]      level_q, level_d;
  logic [IMAGE_SIZE_BITS-1:0] addr_q, addr_d;
  logic [IMAGE_SIZE_BITS+1:0] next_index_q, next_index_d;
  logic                       found_q, found_d;
  logic                       sort_busy_q, sort_busy_d;
  logic                       sort_done_q, sort_done_d;
  logic [PIXEL_BITS-1:0]      pix_q [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0]      pix_d [IMAGE_SIZE];

  logic                       idle_like;
  logic                       wr_ok;
  logic                       hit;
  logic                       last_slot;
  logic [IMAGE_SIZE_BITS-1:0] adv_addr;
  logic [PIXEL_BITS-1:0]      adv_level;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign wr_ok     = bus.img_wr_en && idle_like && ({1'b0, bus.img_wr_addr} < SIZE_EXT);
  assign hit       = (pix_q[addr_q] == level_q);
  assign last_slot = (level_q == LEVEL_MIN) && (addr_q == ADDR_LAST);

  // Address wraps into the next lower level; never evaluated on the last slot, so no level underflow.
  always_comb begin
    adv_addr  = addr_q + IMAGE_SIZE_BITS'(1);
    adv_level = level_q;
    if (addr_q == ADDR_LAST) begin
      adv_addr  = '0;
      adv_level = level_q - PIXEL_BITS'(1);
    end
  end

  always_comb begin
    pix_d = pix_q;
    if (wr_ok) begin
      pix_d[bus.img_wr_addr] = bus.img_wr_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    addr_d       = addr_q;
    next_index_d = next_index_q;
    found_d      = 1'b0;
    sort_busy_d  = sort_busy_q;
    sort_done_d  = sort_done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          level_d     = LEVEL_MAX;
          addr_d      = '0;
          sort_busy_d = 1'b1;
          sort_done_d = 1'b0;
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          // Strobe is registered here so it is visible for the single EMIT cycle.
          next_index_d = {2'b00, addr_q};
          found_d      = 1'b1;
          state_d      = S_EMIT;
        end else if (last_slot) begin
          sort_busy_d = 1'b0;
          sort_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          level_d = adv_level;
          addr_d  = adv_addr;
        end
      end
      S_EMIT: begin
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (bus.aerin_ctrl_busy) begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!bus.aerin_ctrl_busy) begin
          if (last_slot) begin
            sort_busy_d = 1'b0;
            sort_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            level_d = adv_level;
            addr_d  = adv_addr;
            state_d = S_SCAN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      level_q      <= LEVEL_MAX;
      addr_q       <= '0;
      next_index_q <= '0;
      found_q      <= 1'b0;
      sort_busy_q  <= 1'b0;
      sort_done_q  <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        pix_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      addr_q       <= addr_d;
      next_index_q <= next_index_d;
      found_q      <= found_d;
      sort_busy_q  <= sort_busy_d;
      sort_done_q  <= sort_done_d;
      pix_q        <= pix_d;
    end
  end

  assign bus.next_index       = next_index_q;
  assign bus.found_next_index = found_q;
  assign bus.sort_busy        = sort_busy_q;
  assign bus.sort_done        = sort_done_q;
endmodule
`default_nettype wire

// File: tb/tb_rank_order_sorter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rank_order_sorter : randomized and directed checks against an event-list model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rank_order_sorter;
  localparam int N    = 12;
  localparam int PMAX = 11;
  localparam int MINL = 1;
  localparam int FULL_SCAN = (PMAX - MINL + 1) * N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rank_order_sorter_if #(.IMAGE_SIZE(N), .PIXEL_MAX_VALUE(PMAX)) bus ();

  rank_order_sorter #(
    .IMAGE_SIZE     (N),
    .PIXEL_MAX_VALUE(PMAX),
    .MIN_LEVEL      (MINL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int img [N];
  int exp_q[$];
  int got_q[$];
  int drop_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: walk levels top-down, addresses bottom-up, keep equal-value matches.
  function automatic void build_expected();
    exp_q.delete();
    for (int v = PMAX; v >= MINL; v--)
      for (int a = 0; a < N; a++)
        if (img[a] == v) exp_q.push_back(a);
  endfunction

  task automatic write_pix(input int a, input int d);
    @(negedge clk);
    bus.img_wr_en   = 1'b1;
    bus.img_wr_addr = 4'(a);
    bus.img_wr_data = 4'(d);
    @(negedge clk);
    bus.img_wr_en = 1'b0;
    if (a < N) img[a] = d;
  endtask

  task automatic clear_image();
    for (int a = 0; a < N; a++) write_pix(a, 0);
  endtask

  task automatic compare_events(input string tag);
    build_expected();
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_idx"}, got_q[i], exp_q[i]);
  endtask

  task automatic run_sort(input int dly, input int len, output int cycles);
    int wait_cnt = 0;
    int hold_cnt = 0;
    int dbl = 0;
    bit prev = 1'b0;
    bit done = 1'b0;
    got_q.delete();
    drop_i = -1;
    cycles = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.sort_busy), 1);
    chk("done_after_start", int'(bus.sort_done), 0);
    for (int i = 0; i < 4000 && !done; i++) begin
      if (bus.sort_done) begin
        done = 1'b1;
        cycles = i + 1;
      end else begin
        if (bus.found_next_index) begin
          if (prev) dbl++;
          got_q.push_back(int'(bus.next_index));
          if (dly == 0) begin
            bus.aerin_ctrl_busy = 1'b1;
            hold_cnt = len;
          end else begin
            wait_cnt = dly;
          end
        end else if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            bus.aerin_ctrl_busy = 1'b1;
            hold_cnt = len;
          end
        end else if (hold_cnt > 0) begin
          hold_cnt--;
          if (hold_cnt == 0) begin
            bus.aerin_ctrl_busy = 1'b0;
            drop_i = i;
          end
        end
        prev = bus.found_next_index;
        @(negedge clk);
      end
    end
    bus.aerin_ctrl_busy = 1'b0;
    chk("sort_done_seen", int'(done), 1);
    chk("strobe_width", dbl, 0);
    chk("busy_at_done", int'(bus.sort_busy), 0);
  endtask

  task automatic wait_strobe(input int bound, output int idx);
    idx = -1;
    for (int i = 0; i < bound && idx < 0; i++) begin
      @(negedge clk);
      if (bus.found_next_index) idx = int'(bus.next_index);
    end
  endtask

  task automatic busy_pulse();
    @(negedge clk);
    bus.aerin_ctrl_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.aerin_ctrl_busy = 1'b0;
  endtask

  initial begin
    int cyc;
    int idx;
    int cnt;
    bit done;
    bus.img_wr_en = 1'b0;
    bus.img_wr_addr = '0;
    bus.img_wr_data = '0;
    bus.start = 1'b0;
    bus.aerin_ctrl_busy = 1'b0;
    for (int a = 0; a < N; a++) img[a] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_next_index", int'(bus.next_index), 0);
    chk("rst_found", int'(bus.found_next_index), 0);
    chk("rst_busy", int'(bus.sort_busy), 0);
    chk("rst_done", int'(bus.sort_done), 0);

    // Blank image: no events, full scan length.
    run_sort(1, 2, cyc);
    compare_events("blank");
    chk("blank_cycles", cyc, FULL_SCAN);

    // Ties, out-of-range values and an out-of-range address.
    write_pix(5, 11);
    write_pix(3, 11);
    write_pix(9, 2);
    write_pix(1, 15);
    write_pix(10, 14);
    write_pix(13, 11);
    run_sort(1, 4, cyc);
    compare_events("ties");
    if (got_q.size() > 0) chk("ties_first", got_q[0], 3);
    chk("ties_hold_index", int'(bus.next_index), 9);

    // Only the last slot at the minimum level.
    clear_image();
    write_pix(N - 1, MINL);
    run_sort(1, 2, cyc);
    compare_events("last_slot");
    chk("last_done_after_drop", (cyc - 1) - drop_i, 1);

    // Randomized images and handshake timing.
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < 16; a++)
        write_pix(a, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15)));
      run_sort(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), cyc);
      compare_events("rand");
    end

    // Parked handshake; writes and START while busy are ignored.
    clear_image();
    write_pix(2, 8);
    write_pix(4, 5);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_strobe(300, idx);
    chk("park_first", idx, 2);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.found_next_index) cnt++;
      bus.img_wr_en = (k == 5);
      bus.img_wr_addr = 4'd7;
      bus.img_wr_data = 4'd9;
      bus.start = (k == 10);
    end
    @(negedge clk);
    bus.img_wr_en = 1'b0;
    bus.start = 1'b0;
    chk("park_no_strobe", cnt, 0);
    chk("park_busy", int'(bus.sort_busy), 1);
    busy_pulse();
    wait_strobe(300, idx);
    chk("park_second", idx, 4);
    busy_pulse();
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.sort_done) done = 1'b1;
    end
    chk("park_done", int'(done), 1);
    run_sort(2, 3, cyc);
    compare_events("park_rerun");

    // Asynchronous reset while waiting for BUSY to fall.
    clear_image();
    write_pix(6, PMAX);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_strobe(300, idx);
    chk("rst_mid_strobe", idx, 6);
    bus.aerin_ctrl_busy = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_next_index", int'(bus.next_index), 0);
    chk("arst_found", int'(bus.found_next_index), 0);
    chk("arst_busy", int'(bus.sort_busy), 0);
    chk("arst_done", int'(bus.sort_done), 0);
    for (int a = 0; a < N; a++) img[a] = 0;
    @(negedge clk);
    bus.aerin_ctrl_busy = 1'b0;
    rst_n = 1'b1;
    run_sort(1, 2, cyc);
    compare_events("after_reset");
    chk("after_reset_cycles", cyc, FULL_SCAN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
